// File: rtl/mem_check_pkg.sv
// Shared types and helpers for the end-of-program memory result checker.
package mem_check_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [31:0]  STOP_OPCODE_DEF = 32'hff000000;
  localparam int unsigned MAX_DATA_W      = 1024;

  // Callers zero-extend their words to MAX_DATA_W; unused upper bits carry a zero mask.
  function automatic logic masked_mismatch(input logic [MAX_DATA_W-1:0] data,
                                           input logic [MAX_DATA_W-1:0] expv,
                                           input logic [MAX_DATA_W-1:0] mask);
    return |((data ^ expv) & mask);
  endfunction

endpackage

// File: rtl/mem_check_exp_table.sv
// Expected-word/mask register file: one write port, one combinational read port.
module mem_check_exp_table #(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned NUM_WORDS = 14,
  parameter int unsigned IDX_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] wmask,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata_c,
  output logic [DATA_W-1:0] rmask_c
);

  logic [DATA_W-1:0] data_q [NUM_WORDS];
  logic [DATA_W-1:0] mask_q [NUM_WORDS];

  // Masks clear on reset so a fresh table checks nothing; data is left alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      if (!rst_n) begin
        mask_q[i] <= '0;
      end else if (we && (widx == IDX_W'(i))) begin
        mask_q[i] <= wmask;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      if (we && (widx == IDX_W'(i))) begin
        data_q[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    rmask_c = '0;
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      if (ridx == IDX_W'(i)) begin
        rdata_c = data_q[i];
        rmask_c = mask_q[i];
      end
    end
  end

endmodule

// File: rtl/mem_result_checker.sv
// Bus-master memory checker: on STOP or start, reads NUM_WORDS words and
// compares each against a masked expected table, reporting pass/fail details.
module mem_result_checker
  import mem_check_pkg::*;
#(
  parameter int unsigned       DATA_W      = 256,
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       NUM_WORDS   = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       READ_LAT    = 1,
  parameter logic [31:0]       STOP_OPCODE = STOP_OPCODE_DEF,
  parameter int unsigned       CNT_W       = 8
) (
  input  logic                 Clk,
  input  logic                 nReset,
  input  logic [DATA_W-1:0]    InstructDataOut,
  input  logic [DATA_W-1:0]    MemDataOut,
  input  logic                 start,
  input  logic                 rearm,
  input  logic                 exp_we,
  input  logic [5:0]           exp_idx,
  input  logic [DATA_W-1:0]    exp_data,
  input  logic [DATA_W-1:0]    exp_mask,
  output logic [ADDR_W-1:0]    chk_address,
  output logic                 chk_nRead,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [CNT_W-1:0]     mismatch_count,
  output logic [5:0]           first_fail_idx,
  output logic [NUM_WORDS-1:0] fail_map
);

  localparam int unsigned      IDX_W   = 6;
  localparam int unsigned      LAT_W   = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [LAT_W-1:0]      lat, lat_nxt;
  logic [DATA_W-1:0]     cap, cap_nxt;
  logic                  armed, armed_nxt;
  logic [ADDR_W-1:0]     address_nxt;
  logic                  nread_nxt, busy_nxt, done_nxt, fail_nxt;
  logic [CNT_W-1:0]      count_nxt;
  logic [5:0]            first_nxt;
  logic [NUM_WORDS-1:0]  map_nxt;

  logic                  idle_c, stop_hit_c, trig_c, miss_c;
  logic [DATA_W-1:0]     tbl_data_c, tbl_mask_c;
  logic                  unused_c;

  assign unused_c   = ^InstructDataOut[DATA_W-1:32];
  assign idle_c     = (state == IDLE) || (state == DONE);
  assign stop_hit_c = idle_c && armed && (InstructDataOut[31:0] == STOP_OPCODE);
  assign trig_c     = idle_c && (start || stop_hit_c);

  // Writes land only when idle, so a same-cycle trigger already sees the new entry.
  mem_check_exp_table #(
    .DATA_W    (DATA_W),
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W)
  ) u_table (
    .clk     (Clk),
    .rst_n   (nReset),
    .we      (exp_we && idle_c && nReset),
    .widx    (exp_idx),
    .wdata   (exp_data),
    .wmask   (exp_mask),
    .ridx    (idx),
    .rdata_c (tbl_data_c),
    .rmask_c (tbl_mask_c)
  );

  assign miss_c = masked_mismatch(MAX_DATA_W'(cap), MAX_DATA_W'(tbl_data_c),
                                  MAX_DATA_W'(tbl_mask_c));

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    lat_nxt     = lat;
    cap_nxt     = cap;
    armed_nxt   = armed;
    address_nxt = chk_address;
    nread_nxt   = chk_nRead;
    busy_nxt    = busy;
    done_nxt    = done;
    fail_nxt    = fail;
    count_nxt   = mismatch_count;
    first_nxt   = first_fail_idx;
    map_nxt     = fail_map;

    if (stop_hit_c) begin
      armed_nxt = 1'b0;
    end else if (rearm) begin
      armed_nxt = 1'b1;
    end

    case (state)
      IDLE, DONE: begin
        if (trig_c) begin
          state_nxt   = ISSUE;
          idx_nxt     = '0;
          done_nxt    = 1'b0;
          fail_nxt    = 1'b0;
          count_nxt   = '0;
          first_nxt   = '0;
          map_nxt     = '0;
          busy_nxt    = 1'b1;
          nread_nxt   = 1'b0;
          address_nxt = BASE_ADDR;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
        lat_nxt   = '0;
        nread_nxt = 1'b1;
      end
      WAIT: begin
        if (lat == LAT_W'(READ_LAT - 1)) begin
          cap_nxt   = MemDataOut;
          state_nxt = COMPARE;
        end else begin
          lat_nxt = lat + LAT_W'(1);
        end
      end
      COMPARE: begin
        if (miss_c) begin
          map_nxt  = fail_map | (NUM_WORDS'(1) << idx);
          fail_nxt = 1'b1;
          if (mismatch_count != CNT_MAX) begin
            count_nxt = mismatch_count + CNT_W'(1);
          end
          if (!fail) begin
            first_nxt = idx;
          end
        end
        if (idx == IDX_W'(NUM_WORDS - 1)) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          state_nxt   = ISSUE;
          idx_nxt     = idx + IDX_W'(1);
          nread_nxt   = 1'b0;
          address_nxt = BASE_ADDR + ADDR_W'(idx + IDX_W'(1));
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        nread_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state          <= IDLE;
      idx            <= '0;
      lat            <= '0;
      cap            <= '0;
      armed          <= 1'b1;
      chk_address    <= '0;
      chk_nRead      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      fail           <= 1'b0;
      mismatch_count <= '0;
      first_fail_idx <= '0;
      fail_map       <= '0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      lat            <= lat_nxt;
      cap            <= cap_nxt;
      armed          <= armed_nxt;
      chk_address    <= address_nxt;
      chk_nRead      <= nread_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      fail           <= fail_nxt;
      mismatch_count <= count_nxt;
      first_fail_idx <= first_nxt;
      fail_map       <= map_nxt;
    end
  end

endmodule

// File: doc/mem_result_checker.md
Name: mem_result_checker

Overview:
- Synthesisable successor to the top-level end-of-program memory check.
- Watches the instruction bus for the STOP opcode, or accepts a software start pulse.
- Then acts as a bus master: reads NUM_WORDS consecutive MainMemory words and compares each against a loadable expected/mask table.
- Reports pass/fail, a mismatch count, the first failing index and a per-word fail bitmap, so regressions need no hierarchical peeks.

Parameters:
- DATA_W, 256, bus word width
- ADDR_W, 16, bus address width
- NUM_WORDS, 14, words checked (1..64)
- BASE_ADDR, 16'h0000, address of word 0
- READ_LAT, 1, cycles from the nRead-low cycle to data capture (1..4)
- STOP_OPCODE, 32'hff000000, value of InstructDataOut[31:0] that triggers a check
- CNT_W, 8, mismatch counter width

Ports:
- Clk  in  1  clock; all logic on rising edge
- nReset  in  1  synchronous, active-low reset
- InstructDataOut  in  DATA_W  instruction bus (monitored only)
- MemDataOut  in  DATA_W  MainMemory read data
- start  in  1  software start pulse
- rearm  in  1  re-enables STOP detection after a trigger
- exp_we  in  1  expected-table write strobe
- exp_idx  in  6  table index
- exp_data  in  DATA_W  expected word
- exp_mask  in  DATA_W  compare mask (1 = bit checked)
- chk_address  out  ADDR_W  read address
- chk_nRead  out  1  active-low read strobe
- busy  out  1  check in progress
- done  out  1  check complete (sticky)
- fail  out  1  at least one mismatch (valid while done)
- mismatch_count  out  CNT_W  failing word count, saturating
- first_fail_idx  out  6  lowest failing index
- fail_map  out  NUM_WORDS  bit i = word i mismatched

Behaviour:
- Reset (nReset low at a rising edge), including mid-check:
  - State -> IDLE; chk_nRead=1; chk_address=0; busy=0, done=0, fail=0.
  - mismatch_count=0, first_fail_idx=0, fail_map=0; armed=1.
  - All table masks -> 0; data entries keep their contents.
- Trigger: in IDLE or DONE, either condition starts a check:
  - start=1, or
  - armed=1 and InstructDataOut[31:0]==STOP_OPCODE.
- On a STOP trigger, armed clears; it sets again only on a rearm pulse or reset. A held STOP word therefore triggers once.
- Start accept: clears done, fail, count, first_fail_idx, fail_map and the word index; enters ISSUE next cycle.
- Triggers are ignored while busy.
- States:
  - IDLE
  - ISSUE (1 cycle): chk_nRead=0, chk_address=BASE_ADDR+idx.
  - WAIT (READ_LAT cycles): chk_nRead=1, address held; MemDataOut captured at the rising edge ending the last WAIT cycle.
  - COMPARE (1 cycle): mismatch = |((captured ^ exp[idx]) & mask[idx]). On mismatch: set fail_map[idx] and fail; increment count, saturating at 2^CNT_W-1; load first_fail_idx if this is the first failure. Then idx+1 -> ISSUE, or -> DONE after idx==NUM_WORDS-1.
  - DONE: busy=0, done=1; results held until next accept or reset.
- busy=1 in ISSUE, WAIT and COMPARE.
- Timing: per word READ_LAT+2 cycles; total NUM_WORDS*(READ_LAT+2) cycles after accept, then done.
- Masks: all-zero mask means the word is still read but always passes. A partial mask reproduces low-16-bit checks (e.g. mask = 16'hffff zero-extended).
- Table: exp_we writes data+mask at exp_idx in IDLE/DONE only.
  - Writes while busy are dropped.
  - exp_idx >= NUM_WORDS is dropped.
  - Write and trigger in the same cycle: the write lands first, so the check uses the new entry.
- Address arithmetic: BASE_ADDR+idx wraps modulo 2^ADDR_W.

Decomposition:
- Package mem_check_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, COMPARE, DONE)
  - default STOP_OPCODE constant
  - function masked_mismatch(data, exp, mask)
- Sub-module mem_check_exp_table: NUM_WORDS x (2*DATA_W) register file.
  - One write port, one combinational read port indexed by idx.
  - Synchronous mask clear on reset.

Test Plan:
- Load 14 entries equal to memory contents with full masks; pulse start → done after 42 cycles (READ_LAT=1); fail=0, mismatch_count=0, fail_map=0.
- Corrupt word 5 and word 9 in memory → fail=1, mismatch_count=2, first_fail_idx=5, fail_map=14'h0220.
- Entry 10 mask 16'hffff, expected low 16 bits 16'h0024; memory word 10 = {240'h1234…, 16'h0024} → word passes. Change the low half to 16'h0025 → fail_map[10]=1.
- Drive InstructDataOut=32'hff000000 for 100 cycles → exactly one check runs. A second check runs only after a rearm pulse and STOP reappearing.
- Assert nReset low for one cycle while in WAIT of word 3 → next cycle: IDLE, chk_nRead=1, busy=0, done=0, fail_map=0, all masks 0. A following start then passes all words.
- READ_LAT=3, NUM_WORDS=4, BASE_ADDR=16'hfffe → addresses fffe, ffff, 0000, 0001; done 20 cycles after accept. An exp_we during busy leaves the table unchanged.
